// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller with tag/valid/dirty state.
// Hit completes one cycle after acceptance; misses hold mem_valid until mem_ready and stall the CPU.
package dm_cache_pkg;
    localparam int TAG_W   = 18;
    localparam int INDEX_W = 10;
    localparam int LINE_W  = 128;

    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic               we;
    } cache_index_type;

    typedef logic [LINE_W-1:0] cache_data_type;
endpackage

module dm_cache_ctrl
    import dm_cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_valid,
    input  logic                 cpu_rw,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_ready,
    output cache_index_type      data_index,
    output cache_data_type       data_write,
    input  cache_data_type       data_read,
    output logic                 mem_valid,
    output logic                 mem_rw,
    output logic [31:0]          mem_addr,
    output logic [LINE_W-1:0]    mem_wdata,
    input  logic [LINE_W-1:0]    mem_rdata,
    input  logic                 mem_ready
);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITE_BACK,
        ALLOCATE
    } state_t;

    state_t state, next_state;

    logic [TAG_W-1:0]   tag_mem [1 << INDEX_W];
    logic [(1 << INDEX_W)-1:0] valid_bits;
    logic [(1 << INDEX_W)-1:0] dirty_bits;

    logic [TAG_W-1:0]   tag_q;
    logic               valid_q;
    logic               dirty_q;

    logic               req_rw;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [1:0]         req_word;
    logic [31:0]        req_wdata;

    logic               refill_done;
    logic               hit;
    logic               mem_done;
    logic               refill_wr;
    cache_data_type     line_merged;

    logic               unused_addr_lsb;
    assign unused_addr_lsb = ^cpu_addr[1:0];

    assign hit       = valid_q && (tag_q == req_tag);
    assign mem_done  = mem_valid && mem_ready;
    assign refill_wr = (state == ALLOCATE) && !refill_done && mem_done;

    always_comb begin
        line_merged = data_read;
        line_merged[{req_word, 5'b0} +: 32] = req_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state       = state;
        cpu_ready        = 1'b0;
        cpu_rdata        = '0;
        data_index.index = req_index;
        data_index.we    = 1'b0;
        data_write       = '0;
        case (state)
            IDLE: begin
                if (cpu_valid) begin
                    data_index.index = cpu_addr[13:4];
                    next_state       = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    cpu_ready  = 1'b1;
                    next_state = IDLE;
                    if (req_rw) begin
                        data_write    = line_merged;
                        data_index.we = 1'b1;
                    end else begin
                        cpu_rdata = data_read[{req_word, 5'b0} +: 32];
                    end
                end else if (valid_q && dirty_q) begin
                    next_state = WRITE_BACK;
                end else begin
                    next_state = ALLOCATE;
                end
            end
            WRITE_BACK: begin
                if (mem_done) begin
                    next_state = ALLOCATE;
                end
            end
            ALLOCATE: begin
                // Second ALLOCATE cycle re-reads the freshly written line so COMPARE sees it.
                if (refill_done) begin
                    next_state = COMPARE;
                end else if (mem_done) begin
                    data_write    = mem_rdata;
                    data_index.we = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Tag storage has no reset; stale tags are masked by the cleared valid bits.
    always_ff @(posedge clk) begin
        if (!rst && refill_wr) begin
            tag_mem[req_index] <= req_tag;
        end
        tag_q <= tag_mem[data_index.index];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_bits  <= '0;
            dirty_bits  <= '0;
            valid_q     <= 1'b0;
            dirty_q     <= 1'b0;
            req_rw      <= 1'b0;
            req_tag     <= '0;
            req_index   <= '0;
            req_word    <= '0;
            req_wdata   <= '0;
            refill_done <= 1'b0;
            mem_valid   <= 1'b0;
            mem_rw      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            valid_q <= valid_bits[data_index.index];
            dirty_q <= dirty_bits[data_index.index];
            case (state)
                IDLE: begin
                    if (cpu_valid) begin
                        req_rw    <= cpu_rw;
                        req_tag   <= cpu_addr[31:14];
                        req_index <= cpu_addr[13:4];
                        req_word  <= cpu_addr[3:2];
                        req_wdata <= cpu_wdata;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        if (req_rw) begin
                            dirty_bits[req_index] <= 1'b1;
                        end
                    end else begin
                        mem_valid <= 1'b1;
                        if (valid_q && dirty_q) begin
                            mem_rw    <= 1'b1;
                            mem_addr  <= {tag_q, req_index, 4'b0};
                            mem_wdata <= data_read;
                        end else begin
                            mem_rw    <= 1'b0;
                            mem_addr  <= {req_tag, req_index, 4'b0};
                        end
                    end
                end
                WRITE_BACK: begin
                    if (mem_done) begin
                        mem_valid <= 1'b0;
                    end
                end
                ALLOCATE: begin
                    if (refill_done) begin
                        refill_done <= 1'b0;
                    end else if (mem_done) begin
                        mem_valid             <= 1'b0;
                        refill_done           <= 1'b1;
                        valid_bits[req_index] <= 1'b1;
                        dirty_bits[req_index] <= 1'b0;
                    end else if (!mem_valid) begin
                        // Entered from WRITE_BACK: leave one idle cycle before the refill.
                        mem_valid <= 1'b1;
                        mem_rw    <= 1'b0;
                        mem_addr  <= {req_tag, req_index, 4'b0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl against a flat coherent-memory reference model.
module tb_dm_cache_ctrl;
    import dm_cache_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cpu_valid = 1'b0;
    logic            cpu_rw = 1'b0;
    logic [31:0]     cpu_addr = '0;
    logic [31:0]     cpu_wdata = '0;
    logic [31:0]     cpu_rdata;
    logic            cpu_ready;
    cache_index_type data_index;
    cache_data_type  data_write;
    cache_data_type  data_read;
    logic            mem_valid;
    logic            mem_rw;
    logic [31:0]     mem_addr;
    logic [127:0]    mem_wdata;
    logic [127:0]    mem_rdata;
    logic            mem_ready;

    dm_cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .data_index(data_index), .data_write(data_write), .data_read(data_read),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for dm_cache_mem: registered read, write when we=1.
    logic [127:0] line_arr [1024];
    always @(posedge clk) begin
        if (data_index.we) line_arr[data_index.index] <= data_write;
        else               data_read <= line_arr[data_index.index];
    end

    // Reference: main memory, CPU writes overlay, and architectural tag/valid/dirty state.
    logic [127:0] mm [bit [27:0]];
    logic [31:0]  shadow [bit [31:0]];
    logic [17:0]  ref_tag [1024];
    bit           ref_valid [1024];
    bit           ref_dirty [1024];

    typedef struct {
        bit           rw;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } mem_exp_t;
    mem_exp_t    mem_exp_q[$];
    logic [32:0] cpu_exp_q[$];

    int stall_cycles = -1;
    int refill_cyc = 0;
    int wb_cyc = 0;
    bit last_was_wb = 0;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] init_line(input logic [27:0] la);
        logic [127:0] ln;
        logic [31:0]  wa;
        if (la == 28'h100) return {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        for (int k = 0; k < 4; k++) begin
            wa = {la, k[1:0], 2'b00};
            ln[k*32 +: 32] = (wa * 32'h9E37_79B1) ^ 32'h2468_ACE0;
        end
        return ln;
    endfunction

    function automatic logic [127:0] mm_line(input logic [27:0] la);
        if (mm.exists(la)) return mm[la];
        return init_line(la);
    endfunction

    function automatic logic [31:0] view_word(input logic [31:0] a);
        logic [31:0]  wa;
        logic [127:0] ln;
        wa = {a[31:2], 2'b00};
        if (shadow.exists(wa)) return shadow[wa];
        ln = mm_line(a[31:4]);
        return ln[{a[3:2], 5'b0} +: 32];
    endfunction

    function automatic logic [127:0] view_line(input logic [27:0] la);
        logic [127:0] ln;
        for (int k = 0; k < 4; k++) ln[k*32 +: 32] = view_word({la, k[1:0], 2'b00});
        return ln;
    endfunction

    // Main-memory responder: checks each request against expectations and answers after a delay.
    initial begin
        bit          busy;
        int          wait_cnt;
        logic [31:0] cur_addr;
        bit          cur_rw;
        mem_exp_t    e;
        busy = 0; wait_cnt = 0; cur_addr = '0; cur_rw = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (!mem_valid) begin
                busy = 0;
            end else begin
                if (!busy) begin
                    busy     = 1;
                    cur_addr = mem_addr;
                    cur_rw   = mem_rw;
                    wait_cnt = (stall_cycles >= 0) ? stall_cycles : $urandom_range(0, 3);
                    if (!mem_rw && last_was_wb)
                        chk(cyc == wb_cyc + 2, "wb_refill_gap", cyc - wb_cyc, 2);
                    chk(mem_exp_q.size() != 0, "mem_request_expected", mem_addr, 0);
                    if (mem_exp_q.size() != 0) begin
                        e = mem_exp_q.pop_front();
                        chk(mem_rw == e.rw, "mem_rw", mem_rw, e.rw);
                        chk(mem_addr == e.addr, "mem_addr", mem_addr, e.addr);
                        if (e.rw) chk(mem_wdata == e.wdata, "mem_wdata", mem_wdata, e.wdata);
                    end
                end else begin
                    chk(mem_addr == cur_addr && mem_rw == cur_rw, "mem_req_stable", mem_addr, cur_addr);
                    chk(cpu_ready == 1'b0, "no_ready_while_mem", cpu_ready, 0);
                end
                if (wait_cnt == 0) begin
                    mem_ready = 1'b1;
                    busy      = 0;
                    if (cur_rw) begin
                        mm[cur_addr[31:4]] = mem_wdata;
                        last_was_wb = 1;
                        wb_cyc      = cyc;
                    end else begin
                        mem_rdata   = mm_line(cur_addr[31:4]);
                        last_was_wb = 0;
                        refill_cyc  = cyc;
                    end
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // CPU-side monitor: pops one expectation per completion.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (cpu_ready && !rst) begin
                chk(cpu_exp_q.size() != 0, "cpu_ready_expected", cpu_addr, 0);
                if (cpu_exp_q.size() != 0) begin
                    e = cpu_exp_q.pop_front();
                    if (!e[32]) chk(cpu_rdata == e[31:0], "cpu_rdata", cpu_rdata, e[31:0]);
                end
            end
        end
    end

    task automatic issue(input bit rw, input logic [31:0] addr, input logic [31:0] wdata, output bit exp_hit);
        int          idx;
        logic [17:0] tg;
        mem_exp_t    e;
        idx = int'(addr[13:4]);
        tg  = addr[31:14];
        exp_hit = ref_valid[idx] && ref_tag[idx] == tg;
        if (!exp_hit) begin
            if (ref_valid[idx] && ref_dirty[idx]) begin
                e.rw    = 1;
                e.addr  = {ref_tag[idx], addr[13:4], 4'h0};
                e.wdata = view_line({ref_tag[idx], addr[13:4]});
                mem_exp_q.push_back(e);
            end
            e.rw    = 0;
            e.addr  = {tg, addr[13:4], 4'h0};
            e.wdata = '0;
            mem_exp_q.push_back(e);
            ref_tag[idx]   = tg;
            ref_valid[idx] = 1;
            ref_dirty[idx] = 0;
        end
        cpu_exp_q.push_back({rw, view_word(addr)});
        if (rw) begin
            shadow[{addr[31:2], 2'b00}] = wdata;
            ref_dirty[idx] = 1;
        end
        cpu_valid = 1'b1;
        cpu_rw    = rw;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        @(negedge clk);
        while (!cpu_ready && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk(cpu_ready == 1'b1, "cpu_ready_timeout", lat, 200);
        cpu_valid = 1'b0;
    endtask

    task automatic do_req(input bit rw, input logic [31:0] addr, input logic [31:0] wdata);
        bit h;
        int lat;
        issue(rw, addr, wdata, h);
        wait_done(lat);
        if (h) chk(lat == 1, "hit_latency", lat, 1);
        else   chk(cyc - refill_cyc == 2, "refill_to_ready", cyc - refill_cyc, 2);
        @(negedge clk);
    endtask

    task automatic reset_mid_wb();
        bit h;
        int n;
        stall_cycles = 40;
        issue(0, 32'h0000_5008, 32'h0, h);
        n = 0;
        while (!(mem_valid && mem_rw) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(mem_valid && mem_rw, "reach_write_back", {mem_valid, mem_rw}, 2'b11);
        rst = 1'b1;
        cpu_valid = 1'b0;
        @(negedge clk);
        chk(mem_valid == 1'b0, "rst_mem_valid", mem_valid, 0);
        chk(cpu_ready == 1'b0, "rst_cpu_ready", cpu_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            ref_valid[i] = 0;
            ref_dirty[i] = 0;
        end
        shadow.delete();
        cpu_exp_q.delete();
        mem_exp_q.delete();
        stall_cycles = -1;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0]  ridx;
        logic [17:0] rtg;
        logic [31:0] raddr;
        for (int i = 0; i < 1024; i++) begin
            ref_valid[i] = 0;
            ref_dirty[i] = 0;
            ref_tag[i]   = '0;
        end
        repeat (3) @(negedge clk);
        chk(cpu_ready == 1'b0, "reset_cpu_ready", cpu_ready, 0);
        chk(cpu_rdata == 32'h0, "reset_cpu_rdata", cpu_rdata, 0);
        chk(mem_valid == 1'b0, "reset_mem_valid", mem_valid, 0);
        chk(mem_rw == 1'b0, "reset_mem_rw", mem_rw, 0);
        chk(mem_addr == 32'h0, "reset_mem_addr", mem_addr, 0);
        chk(mem_wdata == 128'h0, "reset_mem_wdata", mem_wdata, 0);
        chk(data_index.we == 1'b0, "reset_we", data_index.we, 0);
        rst = 1'b0;
        @(negedge clk);

        do_req(0, 32'h0000_1004, 32'h0);          // cold read, word 1 = BBBB_BBBB
        do_req(0, 32'h0000_1004, 32'h0);          // hit
        do_req(1, 32'h0000_1008, 32'h1234_5678);  // write hit, line dirty
        do_req(0, 32'h0000_5008, 32'h0);          // dirty eviction of 0x1000
        do_req(1, 32'h0000_2000, 32'hCAFE_F00D);  // write miss allocate
        do_req(0, 32'h0000_2000, 32'h0);          // hit, no traffic
        do_req(0, 32'h0000_3FF0, 32'h0);          // top index
        do_req(1, 32'h0000_0000, 32'h0BAD_BEEF);  // bottom index
        do_req(0, 32'h0000_3FFC, 32'h0);
        do_req(0, 32'h0000_0000, 32'h0);
        stall_cycles = 20;
        do_req(0, 32'h0000_3004, 32'h0);          // stalled refill
        stall_cycles = -1;
        do_req(1, 32'h0000_1008, 32'hA5A5_0001);  // make 0x1000 dirty again
        reset_mid_wb();
        do_req(0, 32'h0000_5008, 32'h0);          // refill only, no write-back

        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 3))
                0: ridx = 10'h000;
                1: ridx = 10'h3FF;
                2: ridx = 10'h001;
                default: ridx = 10'h155;
            endcase
            rtg   = 18'($urandom_range(0, 2));
            raddr = {rtg, ridx, 2'($urandom), 2'($urandom)};
            do_req(1'($urandom_range(0, 1)), raddr, $urandom);
        end

        repeat (4) @(negedge clk);
        chk(cpu_exp_q.size() == 0, "cpu_queue_drained", cpu_exp_q.size(), 0);
        chk(mem_exp_q.size() == 0, "mem_queue_drained", mem_exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
